// File: rtl/pipeid_fwd_if.sv
// Bus bundle for the pipeid_fwd ID stage: IF/ID inputs, EX/MEM/WB feedback, PC control and ID/EX outputs.
// The stall_cnt/bubble_cnt signals exist only when PIPEID_PERF_EN is defined.
interface pipeid_fwd_if #(
    parameter int unsigned XLEN = 32
);
    logic            freeze;
    logic [31:0]     inst;
    logic [XLEN-1:0] dpc4;

    logic            ewreg;
    logic            em2reg;
    logic [4:0]      ern;
    logic            mwreg;
    logic            mm2reg;
    logic [4:0]      mrn;
    logic [XLEN-1:0] ealu;
    logic [XLEN-1:0] malu;
    logic [XLEN-1:0] mmo;
    logic            wwreg;
    logic [4:0]      wrn;
    logic [XLEN-1:0] wdi;

    logic            wpcir;
    logic [1:0]      pcsource;
    logic [XLEN-1:0] bpc;
    logic [XLEN-1:0] jpc;

    logic            e_wreg;
    logic            e_m2reg;
    logic            e_wmem;
    logic            e_aluimm;
    logic            e_shift;
    logic            e_jal;
    logic [3:0]      e_aluc;
    logic [4:0]      e_rn;
    logic [XLEN-1:0] e_a;
    logic [XLEN-1:0] e_b;
    logic [XLEN-1:0] e_imm;
    logic [XLEN-1:0] e_pc4;
`ifdef PIPEID_PERF_EN
    logic [31:0]     stall_cnt;
    logic [31:0]     bubble_cnt;
`endif

    // ID stage side
    modport slave (
        input  freeze, inst, dpc4,
        input  ewreg, em2reg, ern, mwreg, mm2reg, mrn, ealu, malu, mmo,
        input  wwreg, wrn, wdi,
        output wpcir, pcsource, bpc, jpc,
        output e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, e_jal,
        output e_aluc, e_rn, e_a, e_b, e_imm, e_pc4
`ifdef PIPEID_PERF_EN
        , output stall_cnt, bubble_cnt
`endif
    );

    // Surrounding pipeline side
    modport master (
        output freeze, inst, dpc4,
        output ewreg, em2reg, ern, mwreg, mm2reg, mrn, ealu, malu, mmo,
        output wwreg, wrn, wdi,
        input  wpcir, pcsource, bpc, jpc,
        input  e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, e_jal,
        input  e_aluc, e_rn, e_a, e_b, e_imm, e_pc4
`ifdef PIPEID_PERF_EN
        , input stall_cnt, bubble_cnt
`endif
    );
endinterface

// File: rtl/pipeid_fwd.sv
// MIPS-subset ID stage: decode, NREG x XLEN register file with write-first bypass, EX/MEM forwarding,
// load-use stall, ID branch/jump resolution and the ID/EX register. PIPEID_PERF_EN adds stall/bubble counters.
module pipeid_fwd #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input logic         clock,
    input logic         reset,
    pipeid_fwd_if.slave bus
);
    localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [4:0]  RA = 5'd31;

    typedef struct packed {
        logic            wreg;
        logic            m2reg;
        logic            wmem;
        logic            aluimm;
        logic            shift;
        logic            jal;
        logic [3:0]      aluc;
        logic [4:0]      rn;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc4;
    } idex_t;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm16;
    logic [25:0] addr;

    assign op    = bus.inst[31:26];
    assign rs    = bus.inst[25:21];
    assign rt    = bus.inst[20:16];
    assign rd    = bus.inst[15:11];
    assign sa    = bus.inst[10:6];
    assign funct = bus.inst[5:0];
    assign imm16 = bus.inst[15:0];
    assign addr  = bus.inst[25:0];

    logic r_op;
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;

    assign r_op   = (op == 6'b000000);
    assign i_add  = r_op && (funct == 6'b100000);
    assign i_sub  = r_op && (funct == 6'b100010);
    assign i_and  = r_op && (funct == 6'b100100);
    assign i_or   = r_op && (funct == 6'b100101);
    assign i_xor  = r_op && (funct == 6'b100110);
    assign i_sll  = r_op && (funct == 6'b000000);
    assign i_srl  = r_op && (funct == 6'b000010);
    assign i_sra  = r_op && (funct == 6'b000011);
    assign i_jr   = r_op && (funct == 6'b001000);
    assign i_addi = (op == 6'b001000);
    assign i_andi = (op == 6'b001100);
    assign i_ori  = (op == 6'b001101);
    assign i_xori = (op == 6'b001110);
    assign i_lui  = (op == 6'b001111);
    assign i_lw   = (op == 6'b100011);
    assign i_sw   = (op == 6'b101011);
    assign i_beq  = (op == 6'b000100);
    assign i_bne  = (op == 6'b000101);
    assign i_j    = (op == 6'b000010);
    assign i_jal  = (op == 6'b000011);

    logic is_shift, is_ralu, dest_rt, dec_wreg, dec_sext, dec_aluimm, use_rs, use_rt;

    assign is_shift   = i_sll || i_srl || i_sra;
    assign is_ralu    = i_add || i_sub || i_and || i_or || i_xor || is_shift;
    assign dest_rt    = i_addi || i_andi || i_ori || i_xori || i_lui || i_lw;
    assign dec_wreg   = is_ralu || dest_rt || i_jal;
    assign dec_sext   = i_addi || i_lw || i_sw || i_beq || i_bne;
    assign dec_aluimm = dest_rt || i_sw;
    assign use_rs     = (is_ralu && !is_shift) || i_jr || i_addi || i_andi || i_ori || i_xori
                      || i_lw || i_sw || i_beq || i_bne;
    assign use_rt     = is_ralu || i_jr || i_sw || i_beq || i_bne;

    // Pipeline ALU code: bit 2 selects sub/or/srl, bit 3 arithmetic right shift.
    logic [3:0] dec_aluc;
    always_comb begin
        dec_aluc = 4'b0000;
        if (i_sub || i_beq || i_bne)      dec_aluc = 4'b0100;
        else if (i_and || i_andi)         dec_aluc = 4'b0001;
        else if (i_or || i_ori)           dec_aluc = 4'b0101;
        else if (i_xor || i_xori)         dec_aluc = 4'b0010;
        else if (i_lui)                   dec_aluc = 4'b0110;
        else if (i_sll)                   dec_aluc = 4'b0011;
        else if (i_srl)                   dec_aluc = 4'b0111;
        else if (i_sra)                   dec_aluc = 4'b1111;
    end

    logic [XLEN-1:0] imm_sext, imm_zext, imm_sa;
    assign imm_sext = {{(XLEN-16){imm16[15]}}, imm16};
    assign imm_zext = XLEN'(imm16);
    assign imm_sa   = XLEN'(sa);

    logic [XLEN-1:0] rf_q [NREG];

    // Operand select per source: EX result, then MEM result/load data, then the bypassed register file.
    logic [1:0][4:0]      src;
    logic [1:0][XLEN-1:0] opnd;
    assign src = {rt, rs};

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            opnd[s] = '0;
            if (bus.ewreg && !bus.em2reg && (bus.ern != 5'd0) && (bus.ern == src[s])) begin
                opnd[s] = bus.ealu;
            end else if (bus.mwreg && (bus.mrn != 5'd0) && (bus.mrn == src[s])) begin
                opnd[s] = bus.mm2reg ? bus.mmo : bus.malu;
            end else if ((src[s] != 5'd0) && (32'(src[s]) < NREG)) begin
                opnd[s] = (bus.wwreg && (bus.wrn == src[s])) ? bus.wdi : rf_q[src[s][AW-1:0]];
            end
        end
    end

    logic stall, wpcir, br_taken;
    assign stall = bus.ewreg && bus.em2reg && (bus.ern != 5'd0)
                && ((use_rs && (bus.ern == rs)) || (use_rt && (bus.ern == rt)));
    assign wpcir    = !(stall || bus.freeze);
    assign br_taken = (i_beq && (opnd[0] == opnd[1])) || (i_bne && (opnd[0] != opnd[1]));

    // A stalled instruction must not redirect the PC until its operands are valid.
    logic [1:0] pcsource;
    always_comb begin
        pcsource = 2'b00;
        if (!stall) begin
            if (i_jr)              pcsource = 2'b10;
            else if (i_j || i_jal) pcsource = 2'b11;
            else if (br_taken)     pcsource = 2'b01;
        end
    end

    assign bus.wpcir    = wpcir;
    assign bus.pcsource = pcsource;
    assign bus.bpc      = bus.dpc4 + (imm_sext << 2);
    assign bus.jpc      = {bus.dpc4[XLEN-1:28], addr, 2'b00};

    idex_t dec_e, idex_d, idex_q;
    always_comb begin
        dec_e        = '0;
        dec_e.wreg   = dec_wreg;
        dec_e.m2reg  = i_lw;
        dec_e.wmem   = i_sw;
        dec_e.aluimm = dec_aluimm;
        dec_e.shift  = is_shift;
        dec_e.jal    = i_jal;
        dec_e.aluc   = dec_aluc;
        dec_e.rn     = i_jal ? RA : (dest_rt ? rt : rd);
        dec_e.a      = opnd[0];
        dec_e.b      = opnd[1];
        dec_e.imm    = is_shift ? imm_sa : (dec_sext ? imm_sext : imm_zext);
        dec_e.pc4    = bus.dpc4;

        // Freeze wins over the stall; the hazard is re-evaluated once freeze drops.
        idex_d = idex_q;
        if (!bus.freeze) begin
            idex_d = stall ? idex_t'('0) : dec_e;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) idex_q <= '0;
        else       idex_q <= idex_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) rf_q[AW'(i)] <= '0;
        end else if (bus.wwreg && (bus.wrn != 5'd0) && (32'(bus.wrn) < NREG)) begin
            rf_q[bus.wrn[AW-1:0]] <= bus.wdi;
        end
    end

    assign bus.e_wreg   = idex_q.wreg;
    assign bus.e_m2reg  = idex_q.m2reg;
    assign bus.e_wmem   = idex_q.wmem;
    assign bus.e_aluimm = idex_q.aluimm;
    assign bus.e_shift  = idex_q.shift;
    assign bus.e_jal    = idex_q.jal;
    assign bus.e_aluc   = idex_q.aluc;
    assign bus.e_rn     = idex_q.rn;
    assign bus.e_a      = idex_q.a;
    assign bus.e_b      = idex_q.b;
    assign bus.e_imm    = idex_q.imm;
    assign bus.e_pc4    = idex_q.pc4;

`ifdef PIPEID_PERF_EN
    // Saturating event counters: PC-hold cycles and bubbles actually loaded.
    logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!wpcir && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (stall && !bus.freeze && (bubble_cnt_q != 32'hFFFF_FFFF)) bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_pipeid_fwd.sv
// Directed bench for pipeid_fwd with an instruction-level reference model checked every cycle.
// Counter checks are compiled in when PIPEID_PERF_EN is defined.
module tb_pipeid_fwd;
    localparam int NREG = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pipeid_fwd_if #(.XLEN(32)) bus ();
    pipeid_fwd #(.XLEN(32), .NREG(NREG)) dut (.clock(clock), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    typedef enum {K_NOP, K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLL, K_SRL, K_SRA, K_JR,
                  K_ADDI, K_ANDI, K_ORI, K_XORI, K_LUI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL} kind_e;

    typedef struct packed {
        bit wreg; bit m2reg; bit wmem; bit aluimm; bit shift; bit jal;
        bit [3:0] aluc; bit [4:0] rn; bit [31:0] a; bit [31:0] b; bit [31:0] imm; bit [31:0] pc4;
    } ex_t;

    typedef struct packed {
        bit stall; bit wpcir; bit [1:0] pcs; bit [31:0] bpc; bit [31:0] jpc; ex_t dec;
    } mres_t;

    logic [31:0] mref [32];
    ex_t         exp_e;
    logic [31:0] m_scnt, m_bcnt;

    function automatic kind_e kind_of(input logic [31:0] w);
        if (w[31:26] == 6'h00) begin
            case (w[5:0])
                6'h20: return K_ADD;  6'h22: return K_SUB;  6'h24: return K_AND;
                6'h25: return K_OR;   6'h26: return K_XOR;  6'h00: return K_SLL;
                6'h02: return K_SRL;  6'h03: return K_SRA;  6'h08: return K_JR;
                default: return K_NOP;
            endcase
        end
        case (w[31:26])
            6'h08: return K_ADDI; 6'h0C: return K_ANDI; 6'h0D: return K_ORI;
            6'h0E: return K_XORI; 6'h0F: return K_LUI;  6'h23: return K_LW;
            6'h2B: return K_SW;   6'h04: return K_BEQ;  6'h05: return K_BNE;
            6'h02: return K_J;    6'h03: return K_JAL;
            default: return K_NOP;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input kind_e k);
        case (k)
            K_SUB, K_BEQ, K_BNE: return 4'd4;
            K_AND, K_ANDI:       return 4'd1;
            K_OR, K_ORI:         return 4'd5;
            K_XOR, K_XORI:       return 4'd2;
            K_LUI:               return 4'd6;
            K_SLL:               return 4'd3;
            K_SRL:               return 4'd7;
            K_SRA:               return 4'd15;
            default:             return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_src(input logic [4:0] r);
        if (bus.ewreg && !bus.em2reg && r != 0 && bus.ern == r) return bus.ealu;
        if (bus.mwreg && r != 0 && bus.mrn == r) return bus.mm2reg ? bus.mmo : bus.malu;
        if (r == 0 || int'(r) >= NREG) return 32'd0;
        if (bus.wwreg && bus.wrn == r) return bus.wdi;
        return mref[r];
    endfunction

    function automatic mres_t model_eval();
        mres_t r;
        kind_e k;
        logic [31:0] w, sx, da, db;
        logic [4:0]  rs, rt;
        bit ursc, urtc, itw;
        w  = bus.inst;
        k  = kind_of(w);
        rs = w[25:21];
        rt = w[20:16];
        sx = {{16{w[15]}}, w[15:0]};
        da = m_src(rs);
        db = m_src(rt);
        itw  = k inside {K_ADDI, K_ANDI, K_ORI, K_XORI, K_LUI, K_LW};
        ursc = !(k inside {K_NOP, K_J, K_JAL, K_LUI, K_SLL, K_SRL, K_SRA});
        urtc = k inside {K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLL, K_SRL, K_SRA, K_JR, K_SW, K_BEQ, K_BNE};
        r = '0;
        r.dec.wreg   = itw || (k inside {K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_SLL, K_SRL, K_SRA, K_JAL});
        r.dec.m2reg  = (k == K_LW);
        r.dec.wmem   = (k == K_SW);
        r.dec.aluimm = itw || (k == K_SW);
        r.dec.shift  = k inside {K_SLL, K_SRL, K_SRA};
        r.dec.jal    = (k == K_JAL);
        r.dec.aluc   = alu_code(k);
        r.dec.rn     = (k == K_JAL) ? 5'd31 : (itw ? rt : w[15:11]);
        r.dec.a      = da;
        r.dec.b      = db;
        if (r.dec.shift) r.dec.imm = {27'd0, w[10:6]};
        else if (k inside {K_ADDI, K_LW, K_SW, K_BEQ, K_BNE}) r.dec.imm = sx;
        else r.dec.imm = {16'd0, w[15:0]};
        r.dec.pc4 = bus.dpc4;
        r.stall = bus.ewreg && bus.em2reg && bus.ern != 0
               && ((ursc && bus.ern == rs) || (urtc && bus.ern == rt));
        r.wpcir = !(r.stall || bus.freeze);
        r.bpc   = bus.dpc4 + sx * 4;
        r.jpc   = {bus.dpc4[31:28], w[25:0], 2'b00};
        if (r.stall)                                 r.pcs = 2'd0;
        else if (k == K_JR)                          r.pcs = 2'd2;
        else if (k == K_J || k == K_JAL)             r.pcs = 2'd3;
        else if ((k == K_BEQ && da == db) || (k == K_BNE && da != db)) r.pcs = 2'd1;
        else                                         r.pcs = 2'd0;
        return r;
    endfunction

    // Reference state advances on the same edge the DUT samples.
    always @(posedge clock) begin
        mres_t m;
        m = model_eval();
        if (reset) begin
            exp_e  = '0;
            m_scnt = 0;
            m_bcnt = 0;
            for (int i = 0; i < 32; i++) mref[i] = 0;
        end else begin
            if (!m.wpcir && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
            if (!bus.freeze && m.stall && m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
            if (!bus.freeze) exp_e = m.stall ? ex_t'('0) : m.dec;
            if (bus.wwreg && bus.wrn != 0 && int'(bus.wrn) < NREG) mref[bus.wrn] = bus.wdi;
        end
    end

    always @(negedge clock) begin
        mres_t m;
        if (cmp_en) begin
            m = model_eval();
            chk("wpcir", 32'(bus.wpcir), 32'(m.wpcir));
            chk("pcsource", 32'(bus.pcsource), 32'(m.pcs));
            chk("bpc", bus.bpc, m.bpc);
            chk("jpc", bus.jpc, m.jpc);
            chk("e_ctrl", 32'({bus.e_wreg, bus.e_m2reg, bus.e_wmem, bus.e_aluimm, bus.e_shift,
                               bus.e_jal, bus.e_aluc, bus.e_rn}),
                32'({exp_e.wreg, exp_e.m2reg, exp_e.wmem, exp_e.aluimm, exp_e.shift,
                     exp_e.jal, exp_e.aluc, exp_e.rn}));
            chk("e_a", bus.e_a, exp_e.a);
            chk("e_b", bus.e_b, exp_e.b);
            chk("e_imm", bus.e_imm, exp_e.imm);
            chk("e_pc4", bus.e_pc4, exp_e.pc4);
`ifdef PIPEID_PERF_EN
            chk("stall_cnt", bus.stall_cnt, m_scnt);
            chk("bubble_cnt", bus.bubble_cnt, m_bcnt);
`endif
        end
    end

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] sa);
        return {6'd0, rs, rt, rd, sa, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask
    task automatic mid();
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        bus.freeze = 0; bus.inst = 32'hFC00_0000; bus.dpc4 = 0;
        bus.ewreg = 0; bus.em2reg = 0; bus.ern = 0; bus.ealu = 0;
        bus.mwreg = 0; bus.mm2reg = 0; bus.mrn = 0; bus.malu = 0; bus.mmo = 0;
        bus.wwreg = 0; bus.wrn = 0; bus.wdi = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        bus.inst = enc_r(6'h20, 5'd6, 5'd5, 5'd0, 5'd0);
        bus.dpc4 = 32'h40;
        nxt();
        cmp_en = 1;
        mid();
        chk("rst_wpcir", 32'(bus.wpcir), 32'd1);
        chk("rst_pcsource", 32'(bus.pcsource), 32'd0);
        nxt();
        chk("rst_e_wreg", 32'(bus.e_wreg), 32'd0);
        chk("rst_e_pc4", bus.e_pc4, 32'd0);
        reset = 0;
        nxt();
        chk("r5_zero", bus.e_a, 32'd0);
        chk("add_rn", 32'(bus.e_rn), 32'd6);
        chk("add_pc4", bus.e_pc4, 32'h40);

        // Write-first bypass from WB
        bus.wwreg = 1; bus.wrn = 3; bus.wdi = 32'h1234;
        bus.inst = enc_r(6'h20, 5'd4, 5'd3, 5'd0, 5'd0);
        nxt();
        chk("wb_bypass", bus.e_a, 32'h1234);
        bus.wwreg = 0;

        // EX has priority over MEM
        bus.ewreg = 1; bus.ern = 2; bus.ealu = 7;
        bus.mwreg = 1; bus.mrn = 2; bus.malu = 9;
        bus.inst = enc_r(6'h22, 5'd1, 5'd2, 5'd2, 5'd0);
        nxt();
        chk("ex_prio_a", bus.e_a, 32'd7);
        chk("ex_prio_b", bus.e_b, 32'd7);
        bus.ewreg = 0; bus.mm2reg = 1; bus.mmo = 32'h55;
        bus.inst = enc_r(6'h24, 5'd5, 5'd2, 5'd3, 5'd0);
        nxt();
        chk("mem_load_fwd", bus.e_a, 32'h55);
        chk("rf_read_b", bus.e_b, 32'h1234);
        idle();

        // Indices at or above NREG read zero and ignore writes
        bus.wwreg = 1; bus.wrn = 20; bus.wdi = 32'hDEAD;
        bus.inst = enc_r(6'h20, 5'd1, 5'd20, 5'd0, 5'd0);
        nxt();
        chk("hi_idx_bypass", bus.e_a, 32'd0);
        bus.wrn = 15; bus.wdi = 32'hABC;
        bus.inst = enc_r(6'h20, 5'd1, 5'd20, 5'd15, 5'd0);
        nxt();
        chk("hi_idx_read", bus.e_a, 32'd0);
        chk("top_idx_bypass", bus.e_b, 32'hABC);
        bus.wwreg = 0;
        bus.inst = enc_r(6'h20, 5'd1, 5'd15, 5'd20, 5'd0);
        nxt();
        chk("top_idx_read", bus.e_a, 32'hABC);

        // Load-use on beq, then resolved through MEM load data
        bus.ewreg = 1; bus.em2reg = 1; bus.ern = 8;
        bus.inst = enc_i(6'h04, 5'd8, 5'd0, 16'd3); bus.dpc4 = 32'h100;
        mid();
        chk("lu_wpcir", 32'(bus.wpcir), 32'd0);
        chk("lu_pcsource", 32'(bus.pcsource), 32'd0);
        nxt();
        chk("bubble_pc4", bus.e_pc4, 32'd0);
        bus.ewreg = 0; bus.em2reg = 0;
        bus.mwreg = 1; bus.mm2reg = 1; bus.mrn = 8; bus.mmo = 0;
        mid();
        chk("beq_taken", 32'(bus.pcsource), 32'd1);
        chk("beq_bpc", bus.bpc, 32'h10C);
        nxt();
        chk("beq_imm", bus.e_imm, 32'd3);
        chk("beq_pc4", bus.e_pc4, 32'h100);
        idle();

        bus.inst = enc_i(6'h05, 5'd3, 5'd0, 16'hFFFE); bus.dpc4 = 32'h200;
        mid();
        chk("bne_taken", 32'(bus.pcsource), 32'd1);
        chk("bne_back_bpc", bus.bpc, 32'h1F8);
        nxt();
        bus.inst = enc_i(6'h04, 5'd3, 5'd0, 16'hFFFE);
        mid();
        chk("beq_not_taken", 32'(bus.pcsource), 32'd0);
        nxt();

        // Jumps
        bus.inst = {6'h03, 26'h0000100}; bus.dpc4 = 32'h3000_0040;
        mid();
        chk("jal_pcsource", 32'(bus.pcsource), 32'd3);
        chk("jal_jpc", bus.jpc, 32'h3000_0400);
        nxt();
        chk("jal_e_jal", 32'(bus.e_jal), 32'd1);
        chk("jal_rn", 32'(bus.e_rn), 32'd31);
        chk("jal_pc4", bus.e_pc4, 32'h3000_0040);
        bus.inst = {6'h02, 26'h3FF_FFFF}; bus.dpc4 = 32'hF000_0000;
        mid();
        chk("j_jpc", bus.jpc, 32'hFFFF_FFFC);
        nxt();
        bus.ewreg = 1; bus.ern = 3; bus.ealu = 32'h4444;
        bus.inst = enc_r(6'h08, 5'd0, 5'd3, 5'd0, 5'd0);
        mid();
        chk("jr_pcsource", 32'(bus.pcsource), 32'd2);
        nxt();
        chk("jr_fwd_a", bus.e_a, 32'h4444);
        idle();

        // Immediate forms, shifts, memory ops and unknown opcode
        bus.inst = enc_i(6'h08, 5'd3, 5'd7, 16'hFFFF);
        nxt();
        chk("addi_sext", bus.e_imm, 32'hFFFF_FFFF);
        chk("addi_rn", 32'(bus.e_rn), 32'd7);
        bus.inst = enc_i(6'h0C, 5'd3, 5'd7, 16'h8000);
        nxt();
        chk("andi_zext", bus.e_imm, 32'h0000_8000);
        bus.ewreg = 1; bus.em2reg = 1; bus.ern = 9;
        bus.inst = enc_i(6'h0F, 5'd9, 5'd1, 16'h1234);
        mid();
        chk("lui_no_stall", 32'(bus.wpcir), 32'd1);
        nxt();
        chk("lui_aluc", 32'(bus.e_aluc), 32'd6);
        bus.inst = enc_r(6'h00, 5'd2, 5'd9, 5'd3, 5'd5);
        mid();
        chk("sll_rs_unused", 32'(bus.wpcir), 32'd1);
        nxt();
        chk("sll_shamt", bus.e_imm, 32'd5);
        bus.ern = 3;
        mid();
        chk("sll_rt_stall", 32'(bus.wpcir), 32'd0);
        nxt();
        idle();
        bus.inst = enc_i(6'h2B, 5'd2, 5'd3, 16'd4);
        nxt();
        chk("sw_wmem", 32'(bus.e_wmem), 32'd1);
        bus.inst = enc_i(6'h23, 5'd6, 5'd5, 16'd8);
        nxt();
        chk("lw_m2reg", 32'(bus.e_m2reg), 32'd1);
        bus.inst = 32'hFFFF_FFFF;
        nxt();
        chk("unknown_nop", 32'({bus.e_wreg, bus.e_wmem}), 32'd0);

        // Reset while a load-use stall is pending
        bus.ewreg = 1; bus.em2reg = 1; bus.ern = 8;
        bus.inst = enc_i(6'h04, 5'd8, 5'd0, 16'd3);
        reset = 1;
        nxt();
        chk("rst_mid_stall", bus.e_pc4, 32'd0);
        idle();
        nxt();
        reset = 0;
        bus.inst = enc_r(6'h20, 5'd4, 5'd3, 5'd0, 5'd0);
        nxt();
        chk("rf_cleared", bus.e_a, 32'd0);

        // Freeze over a load-use stall: hold, then bubble, then the instruction
        bus.inst = enc_i(6'h0D, 5'd3, 5'd9, 16'h00F0);
        nxt();
        chk("ori_imm", bus.e_imm, 32'hF0);
        bus.ewreg = 1; bus.em2reg = 1; bus.ern = 9; bus.freeze = 1;
        bus.inst = enc_r(6'h20, 5'd10, 5'd9, 5'd9, 5'd0);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("frz_wpcir", 32'(bus.wpcir), 32'd0);
            nxt();
            chk("frz_hold_rn", 32'(bus.e_rn), 32'd9);
        end
        bus.freeze = 0;
        nxt();
        chk("frz_bubble", 32'({bus.e_wreg, bus.e_rn}), 32'd0);
        bus.ewreg = 0; bus.em2reg = 0;
        bus.mwreg = 1; bus.mm2reg = 1; bus.mrn = 9; bus.mmo = 32'h77;
        nxt();
        chk("frz_after_a", bus.e_a, 32'h77);
        chk("frz_after_rn", 32'(bus.e_rn), 32'd10);
`ifdef PIPEID_PERF_EN
        chk("perf_stall", bus.stall_cnt, 32'd4);
        chk("perf_bubble", bus.bubble_cnt, 32'd1);
`endif
        idle();
        nxt();
        mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
